pc_sequencer: RTL

//  Parametrised next-generation PC register: holds the fetch PC, steps it each cycle, and applies

---
 rtl/pc_sequencer_if.sv | 35 +++
 rtl/pc_sequencer.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/pc_sequencer_if.sv
// Bundle between the control/hazard unit (master) and the PC sequencer
// (slave). It carries the redirect requests into the sequencer and the
// registered PC and status pulses back out.
//
// Handshake: there is no valid/ready pair. Every request is a level that is
// sampled at each rising clock edge. The master must hold jump, call and ret
// stable for as long as i_stall is high. The slave's outputs are registers
// that are valid for the whole cycle after the edge that produced them.
interface pc_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             i_stall;
    logic             i_exc_valid;
    logic [1:0]       i_jump;
    logic [WIDTH-1:0] i_jump_add;
    logic [WIDTH-1:0] i_jump_forward_add;
    logic             i_call;
    logic             i_ret;
    logic [WIDTH-1:0] o_pc;
    logic             o_redirected;
    logic             o_align_err;
    logic             o_ras_underflow;

    modport master (
        output i_stall, i_exc_valid, i_jump, i_jump_add, i_jump_forward_add,
               i_call, i_ret,
        input  o_pc, o_redirected, o_align_err, o_ras_underflow
    );

    modport slave (
        input  i_stall, i_exc_valid, i_jump, i_jump_add, i_jump_forward_add,
               i_call, i_ret,
        output o_pc, o_redirected, o_align_err, o_ras_underflow
    );
endinterface

// File: rtl/pc_sequencer.sv
// Parametrised fetch-PC register. Each cycle it steps the PC by STEP or
// loads a redirect target. Redirect priority, highest first: exception,
// stall, return, jump, forward jump. Redirect targets are forced to STEP
// alignment, and a misaligned target is flagged for one cycle.
// Optional return-address stack: define macro PC_RAS_EN to enable it.
// Without it, call/ret are ignored and o_ras_underflow stays 0.
module pc_sequencer #(
    parameter int               WIDTH        = 32,
    parameter int               STEP         = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'('h80),
    parameter int               RAS_DEPTH    = 4
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    pc_sequencer_if.slave        bus
);
    // STEP is a power of two, so its low bits form the alignment mask.
    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(STEP - 1);
    localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);

    logic [WIDTH-1:0] r_pc;
    logic             r_redirected;
    logic             r_align_err;
    logic             r_ras_underflow;

    logic [WIDTH-1:0] w_next_pc;
    logic [WIDTH-1:0] w_seq_pc;
    logic [WIDTH-1:0] w_target;
    logic             w_redirect;
    logic             w_align_err;
    logic             w_underflow;
    logic             w_push;
    logic             w_pop;

    assign w_seq_pc = r_pc + STEP_W;

`ifdef PC_RAS_EN
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic [WIDTH-1:0] r_ras [RAS_DEPTH];
    logic [PTR_W-1:0] r_top;
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] w_top_inc;
    logic [PTR_W-1:0] w_top_dec;
    logic [WIDTH-1:0] w_top_entry;

    // The stack is circular: a push beyond full overwrites the oldest slot.
    assign w_top_inc   = (r_top == PTR_W'(RAS_DEPTH - 1)) ? '0 : r_top + PTR_W'(1);
    assign w_top_dec   = (r_top == '0) ? PTR_W'(RAS_DEPTH - 1) : r_top - PTR_W'(1);
    assign w_top_entry = r_ras[r_top];
`else
    // Without the stack, call/ret and the depth have no function.
    logic w_unused;
    assign w_unused = &{1'b0, bus.i_call, bus.i_ret, (RAS_DEPTH >= 2)};
`endif

    // Next-PC selection in priority order, with alignment and stack requests.
    always_comb begin
        w_next_pc   = r_pc;
        w_target    = '0;
        w_redirect  = 1'b0;
        w_align_err = 1'b0;
        w_underflow = 1'b0;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        if (bus.i_exc_valid) begin
            w_next_pc  = EXC_VECTOR;
            w_redirect = 1'b1;
        end else if (bus.i_stall) begin
            w_next_pc = r_pc;
        end else begin
`ifdef PC_RAS_EN
            w_push = bus.i_call && (bus.i_jump != 2'b00);
            if (bus.i_ret) begin
                w_redirect = 1'b1;
                if (r_count != '0) begin
                    w_pop     = 1'b1;
                    w_next_pc = w_top_entry;
                end else begin
                    w_underflow = 1'b1;
                    w_target    = bus.i_jump_add;
                    w_align_err = |(w_target & ALIGN_MASK);
                    w_next_pc   = w_target & ~ALIGN_MASK;
                end
            end else
`endif
            if (bus.i_jump[0]) begin
                w_redirect  = 1'b1;
                w_target    = bus.i_jump_add;
                w_align_err = |(w_target & ALIGN_MASK);
                w_next_pc   = w_target & ~ALIGN_MASK;
            end else if (bus.i_jump == 2'b10) begin
                w_redirect  = 1'b1;
                w_target    = bus.i_jump_forward_add;
                w_align_err = |(w_target & ALIGN_MASK);
                w_next_pc   = w_target & ~ALIGN_MASK;
            end else begin
                w_next_pc = w_seq_pc;
            end
        end
    end

    // PC and status pulses; reset overrides every request.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_pc            <= RESET_VECTOR;
            r_redirected    <= 1'b0;
            r_align_err     <= 1'b0;
            r_ras_underflow <= 1'b0;
        end else begin
            r_pc            <= w_next_pc;
            r_redirected    <= w_redirect;
            r_align_err     <= w_align_err;
            r_ras_underflow <= w_underflow;
        end
    end

`ifdef PC_RAS_EN
    // Stack pointer and saturating occupancy. Pop-then-push keeps both as is.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_top   <= '0;
            r_count <= '0;
        end else if (w_push && !w_pop) begin
            r_top <= w_top_inc;
            if (r_count != CNT_W'(RAS_DEPTH)) begin
                r_count <= r_count + CNT_W'(1);
            end
        end else if (w_pop && !w_push) begin
            r_top   <= w_top_dec;
            r_count <= r_count - CNT_W'(1);
        end
    end

    // Stack storage: a lone push fills the next slot, pop-then-push replaces the top.
    always_ff @(posedge i_clock) begin
        if (i_reset && w_push) begin
            if (w_pop) begin
                r_ras[r_top] <= w_seq_pc;
            end else begin
                r_ras[w_top_inc] <= w_seq_pc;
            end
        end
    end
`else
    logic w_unused_stack;
    assign w_unused_stack = &{1'b0, w_push, w_pop, w_underflow};
`endif

    assign bus.o_pc            = r_pc;
    assign bus.o_redirected    = r_redirected;
    assign bus.o_align_err     = r_align_err;
    assign bus.o_ras_underflow = r_ras_underflow;
endmodule
